tinyalu_cmd_driver: RTL and testbench
=====================================

// Module: tinyalu_cmd_driver
// PURPOSE
//  Pin-level consumer of ALU operation commands: dequeues {A,B,op} commands, runs each on the TinyALU
//  start/done pin protocol, returns one response per command. Command side is valid/ready with an
//  internal FIFO. Sits between the stimulus source and the TinyALU DUT pins.
// PARAMETERS
//  DEPTH    4    command FIFO entries (power of 2, >=2)
//  TIMEOUT  64   max cycles with alu_start high awaiting alu_done before abort (>=4)
// PORTS
//  clk          in   1   rising-edge clock
//  reset_n      in   1   asynchronous active-low reset
//  cmd_valid    in   1   command offered
//  cmd_ready    out  1   FIFO can accept (= !full)
//  cmd_a        in   8   operand A
//  cmd_b        in   8   operand B
//  cmd_op       in   3   0 no_op, 1 add, 2 and, 3 xor, 4 mul, 5-7 illegal
//  alu_a        out  8   to TinyALU A
//  alu_b        out  8   to TinyALU B
//  alu_op       out  3   to TinyALU op
//  alu_start    out  1   to TinyALU start
//  alu_done     in   1   from TinyALU done
//  alu_result   in   16  from TinyALU result
//  rsp_valid    out  1   response available
//  rsp_ready    in   1   response consumed
//  rsp_result   out  16  result of completed command
//  rsp_op       out  3   op of completed command
//  rsp_err      out  1   1 = illegal op or timeout
// BEHAVIOUR
//  - Reset: all outputs 0 except cmd_ready=1; FIFO empty, FSM IDLE, timeout counter 0. Reset mid-op
//    drops alu_start at once, discards queued commands and any pending response.
//  - FIFO: push when cmd_valid&&cmd_ready; cmd_ready is registered !full. Full + cmd_valid: no push,
//    input ignored. Pointers wrap mod DEPTH. Push and pop in one cycle: count unchanged.
//  - FSM IDLE: FIFO non-empty -> pop, load alu_a/b/op from head. op 1-4 -> BUSY with alu_start=1
//    from the next cycle. op 0 -> RESP (result 0, err 0), ALU not touched. op 5-7 -> RESP (result 0,
//    err 1), ALU not touched. Latency: command accepted at edge N, alu_start high after edge N+1
//    when FSM was idle.
//  - BUSY: alu_start held 1, alu_a/b/op stable, counter++ each cycle. alu_done=1 sampled -> capture
//    alu_result, alu_start=0, go RESP. Counter reaching TIMEOUT with no done -> alu_start=0,
//    rsp_err=1, rsp_result=0, go RESP. alu_done while IDLE/RESP is ignored.
//  - RESP: rsp_valid=1; rsp_result/op/err stable until rsp_ready sampled 1, then rsp_valid=0,
//    counter cleared, go IDLE. Min 2 cycles start-low between consecutive ALU ops (RESP + IDLE).
//  - alu_a/b/op keep last value outside BUSY. FIFO keeps accepting while FSM busy.
//  - One response per accepted command, in acceptance order; no reordering, no drops except reset.
// TESTING (bench instantiates a TinyALU model, 1-cycle add/and/xor, 3-cycle mul)
//  - A=FF,B=01,add -> start held until done, rsp_result=0x0100, rsp_op=1, rsp_err=0
//  - FE*03 mul, 55&FF and, 55^FF xor back-to-back -> 0x02FA, 0x0055, 0x00AA in order;
//    start low >=2 cycles between ops
//  - rsp_ready=0, push 6 cmds with DEPTH=4 -> cmd_ready low after 5 accepted (4 queued + 1 in FSM);
//    release rsp_ready -> all 5 responses in order
//  - cmd_op=0 and cmd_op=6 -> alu_start never rises; responses {0,err0} and {0,err1}
//  - ALU model never asserts done -> alu_start drops after TIMEOUT=64 cycles, rsp_err=1, next cmd runs
//  - reset_n low while BUSY -> alu_start=0 and rsp_valid=0 asynchronously, cmd_ready=1, FIFO empty

Source files
------------

// File: rtl/tinyalu_cmd_driver.sv
// Command driver for the TinyALU pin protocol: queues {A,B,op} commands in a small FIFO,
// runs each through start/done, and returns one in-order response per command.
module tinyalu_cmd_driver #(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [7:0]  cmd_a,
  input  logic [7:0]  cmd_b,
  input  logic [2:0]  cmd_op,
  output logic [7:0]  alu_a,
  output logic [7:0]  alu_b,
  output logic [2:0]  alu_op,
  output logic        alu_start,
  input  logic        alu_done,
  input  logic [15:0] alu_result,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [15:0] rsp_result,
  output logic [2:0]  rsp_op,
  output logic        rsp_err
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned TW = $clog2(TIMEOUT + 1);

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] b;
    logic [2:0] op;
  } cmd_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  cmd_t          mem [DEPTH];
  cmd_t          head_c;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [CW-1:0] count_d;
  logic          push_c;
  logic          pop_c;
  logic          empty_c;
  logic          timeout_c;

  state_t        state_q;
  state_t        state_d;
  logic [TW-1:0] cnt_q;
  logic [TW-1:0] cnt_d;

  logic [7:0]    alu_a_d;
  logic [7:0]    alu_b_d;
  logic [2:0]    alu_op_d;
  logic          alu_start_d;
  logic          rsp_valid_d;
  logic [15:0]   rsp_result_d;
  logic [2:0]    rsp_op_d;
  logic          rsp_err_d;

  function automatic logic is_alu_op(input logic [2:0] op);
    return op inside {3'd1, 3'd2, 3'd3, 3'd4};
  endfunction

  assign push_c    = cmd_valid && cmd_ready;
  assign empty_c   = (count == '0);
  assign head_c    = mem[rd_ptr];
  assign timeout_c = (cnt_q == TW'(TIMEOUT - 1));

  // Command storage
  always_ff @(posedge clk) begin
    if (push_c) begin
      mem[wr_ptr] <= '{a: cmd_a, b: cmd_b, op: cmd_op};
    end
  end

  always_comb begin
    count_d = count;
    case ({push_c, pop_c})
      2'b10:   count_d = count + CW'(1);
      2'b01:   count_d = count - CW'(1);
      default: count_d = count;
    endcase
  end

  // FIFO pointers; cmd_ready is a registered !full
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      cmd_ready <= 1'b1;
    end else begin
      if (push_c) wr_ptr <= wr_ptr + PW'(1);
      if (pop_c)  rd_ptr <= rd_ptr + PW'(1);
      count     <= count_d;
      cmd_ready <= (count_d != CW'(DEPTH));
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (!empty_c) state_d = is_alu_op(head_c.op) ? BUSY : RESP;
      end
      BUSY: begin
        if (alu_done || timeout_c) state_d = RESP;
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Next values of the registered pins; everything holds unless the current state changes it
  always_comb begin
    pop_c        = 1'b0;
    cnt_d        = cnt_q;
    alu_a_d      = alu_a;
    alu_b_d      = alu_b;
    alu_op_d     = alu_op;
    alu_start_d  = alu_start;
    rsp_valid_d  = rsp_valid;
    rsp_result_d = rsp_result;
    rsp_op_d     = rsp_op;
    rsp_err_d    = rsp_err;
    case (state_q)
      IDLE: begin
        if (!empty_c) begin
          pop_c = 1'b1;
          if (is_alu_op(head_c.op)) begin
            alu_a_d     = head_c.a;
            alu_b_d     = head_c.b;
            alu_op_d    = head_c.op;
            alu_start_d = 1'b1;
            cnt_d       = '0;
          end else begin
            // no_op and illegal ops answer directly without touching the ALU
            rsp_valid_d  = 1'b1;
            rsp_result_d = '0;
            rsp_op_d     = head_c.op;
            rsp_err_d    = (head_c.op != 3'd0);
          end
        end
      end
      BUSY: begin
        if (alu_done) begin
          alu_start_d  = 1'b0;
          rsp_valid_d  = 1'b1;
          rsp_result_d = alu_result;
          rsp_op_d     = alu_op;
          rsp_err_d    = 1'b0;
        end else if (timeout_c) begin
          alu_start_d  = 1'b0;
          rsp_valid_d  = 1'b1;
          rsp_result_d = '0;
          rsp_op_d     = alu_op;
          rsp_err_d    = 1'b1;
        end else begin
          cnt_d = cnt_q + TW'(1);
        end
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          cnt_d       = '0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q      <= '0;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_op     <= '0;
      alu_start  <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_result <= '0;
      rsp_op     <= '0;
      rsp_err    <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      alu_a      <= alu_a_d;
      alu_b      <= alu_b_d;
      alu_op     <= alu_op_d;
      alu_start  <= alu_start_d;
      rsp_valid  <= rsp_valid_d;
      rsp_result <= rsp_result_d;
      rsp_op     <= rsp_op_d;
      rsp_err    <= rsp_err_d;
    end
  end

endmodule

// File: tb/tb_tinyalu_cmd_driver.sv
// Bench for tinyalu_cmd_driver with a behavioural TinyALU (1-cycle add/and/xor, 3-cycle mul).
module tb_tinyalu_cmd_driver;

  localparam int unsigned DEPTH   = 4;
  localparam int unsigned TIMEOUT = 64;

  logic        clk;
  logic        reset_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [7:0]  cmd_a;
  logic [7:0]  cmd_b;
  logic [2:0]  cmd_op;
  logic [7:0]  alu_a;
  logic [7:0]  alu_b;
  logic [2:0]  alu_op;
  logic        alu_start;
  logic        alu_done;
  logic [15:0] alu_result;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [15:0] rsp_result;
  logic [2:0]  rsp_op;
  logic        rsp_err;

  int errors = 0;
  int checks = 0;

  tinyalu_cmd_driver #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_a      (cmd_a),
    .cmd_b      (cmd_b),
    .cmd_op     (cmd_op),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_op     (alu_op),
    .alu_start  (alu_start),
    .alu_done   (alu_done),
    .alu_result (alu_result),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_result (rsp_result),
    .rsp_op     (rsp_op),
    .rsp_err    (rsp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // TinyALU model; model_hang suppresses done entirely
  logic model_hang;
  int   m_cnt;

  function automatic int lat(input logic [2:0] op);
    return (op == 3'd4) ? 3 : 1;
  endfunction

  function automatic logic [15:0] model_res(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op);
    case (op)
      3'd1:    return 16'(a) + 16'(b);
      3'd2:    return {8'h00, a & b};
      3'd3:    return {8'h00, a ^ b};
      3'd4:    return 16'(a) * 16'(b);
      default: return 16'h0000;
    endcase
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_cnt      <= 0;
      alu_done   <= 1'b0;
      alu_result <= 16'h0000;
    end else if (!alu_start || alu_done) begin
      m_cnt    <= 0;
      alu_done <= 1'b0;
    end else if (!model_hang) begin
      if (m_cnt + 1 == lat(alu_op)) begin
        alu_done   <= 1'b1;
        alu_result <= model_res(alu_a, alu_b, alu_op);
      end else begin
        m_cnt <= m_cnt + 1;
      end
    end
  end

  // Pin monitor: start rises, shortest start-low gap, pin stability while start is high
  int          rises = 0;
  int          min_gap = 1000;
  int          low_len = 0;
  int          stab_viol = 0;
  logic        seen_fall = 1'b0;
  logic        start_prev = 1'b0;
  logic [18:0] prev_pins = '0;

  always @(negedge clk) begin
    if (alu_start && !start_prev) begin
      rises++;
      if (seen_fall && low_len < min_gap) min_gap = low_len;
    end
    if (alu_start && start_prev && {alu_a, alu_b, alu_op} !== prev_pins) stab_viol++;
    if (!alu_start && start_prev) begin
      seen_fall = 1'b1;
      low_len   = 0;
    end
    if (!alu_start) low_len++;
    start_prev = alu_start;
    prev_pins  = {alu_a, alu_b, alu_op};
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Caller sits at a negedge; returns at the negedge after the accepting edge
  task automatic push_cmd(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op,
                          input int budget, output bit ok);
    cmd_a     = a;
    cmd_b     = b;
    cmd_op    = op;
    cmd_valid = 1'b1;
    ok        = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (cmd_ready) ok = 1'b1;
      @(negedge clk);
      if (ok) break;
    end
    cmd_valid = 1'b0;
  endtask

  task automatic get_rsp(input int budget, output bit ok, output logic [15:0] res,
                         output logic [2:0] op, output logic err);
    ok  = 1'b0;
    res = '0;
    op  = '0;
    err = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (rsp_valid && rsp_ready) begin
        ok  = 1'b1;
        res = rsp_result;
        op  = rsp_op;
        err = rsp_err;
      end
      @(negedge clk);
      if (ok) break;
    end
  endtask

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic [2:0]  op;
    logic [15:0] exp_res;
    logic        exp_err;
  } vec_t;

  localparam int NV = 12;
  vec_t vecs [NV];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no completion, expected finish");
    $fatal(1);
  end

  initial begin
    bit          ok;
    logic [15:0] res;
    logic [2:0]  op;
    logic        err;
    int          r0;
    int          n_alu;
    int          acc;
    int          hi;
    logic        flag;

    vecs[0]  = '{8'hFF, 8'h01, 3'd1, 16'h0100, 1'b0};
    vecs[1]  = '{8'hFE, 8'h03, 3'd4, 16'h02FA, 1'b0};
    vecs[2]  = '{8'h55, 8'hFF, 3'd2, 16'h0055, 1'b0};
    vecs[3]  = '{8'h55, 8'hFF, 3'd3, 16'h00AA, 1'b0};
    vecs[4]  = '{8'h12, 8'h34, 3'd0, 16'h0000, 1'b0};
    vecs[5]  = '{8'h12, 8'h34, 3'd6, 16'h0000, 1'b1};
    vecs[6]  = '{8'h80, 8'h80, 3'd4, 16'h4000, 1'b0};
    vecs[7]  = '{8'h7F, 8'h7F, 3'd1, 16'h00FE, 1'b0};
    vecs[8]  = '{8'hAA, 8'h0F, 3'd7, 16'h0000, 1'b1};
    vecs[9]  = '{8'hF0, 8'h3C, 3'd2, 16'h0030, 1'b0};
    vecs[10] = '{8'hC3, 8'h5A, 3'd3, 16'h0099, 1'b0};
    vecs[11] = '{8'h00, 8'hFF, 3'd5, 16'h0000, 1'b1};

    reset_n    = 1'b0;
    cmd_valid  = 1'b0;
    cmd_a      = '0;
    cmd_b      = '0;
    cmd_op     = '0;
    rsp_ready  = 1'b0;
    model_hang = 1'b0;
    repeat (3) @(negedge clk);

    check("reset_cmd_ready", 32'(cmd_ready), 32'd1);
    check("reset_alu_start", 32'(alu_start), 32'd0);
    check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    check("reset_alu_pins", 32'({alu_a, alu_b, alu_op}), 32'd0);
    check("reset_rsp_pins", 32'({rsp_result, rsp_op, rsp_err}), 32'd0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // Table: all commands streamed back-to-back, responses checked in order
    rsp_ready = 1'b1;
    r0 = rises;
    n_alu = 0;
    for (int i = 0; i < NV; i++) if (vecs[i].op inside {3'd1, 3'd2, 3'd3, 3'd4}) n_alu++;
    fork
      begin
        bit pok;
        for (int i = 0; i < NV; i++) begin
          push_cmd(vecs[i].a, vecs[i].b, vecs[i].op, 200, pok);
          check($sformatf("vec%0d_accepted", i), 32'(pok), 32'd1);
        end
      end
      begin
        bit          gok;
        logic [15:0] gres;
        logic [2:0]  gop;
        logic        gerr;
        for (int i = 0; i < NV; i++) begin
          get_rsp(400, gok, gres, gop, gerr);
          check($sformatf("vec%0d_rsp_seen", i), 32'(gok), 32'd1);
          check($sformatf("vec%0d_result", i), 32'(gres), 32'(vecs[i].exp_res));
          check($sformatf("vec%0d_op", i), 32'(gop), 32'(vecs[i].op));
          check($sformatf("vec%0d_err", i), 32'(gerr), 32'(vecs[i].exp_err));
        end
      end
    join
    repeat (5) @(negedge clk);
    check("table_start_rises", 32'(rises - r0), 32'(n_alu));

    // Backpressure: 4 queued plus 1 held in the FSM, sixth refused
    rsp_ready = 1'b0;
    acc = 0;
    for (int i = 1; i <= 6; i++) begin
      push_cmd(8'(i), 8'(i), 3'd1, 8, ok);
      if (ok) acc++;
    end
    check("bp_accepted", 32'(acc), 32'd5);
    check("bp_cmd_ready_low", 32'(cmd_ready), 32'd0);
    rsp_ready = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      get_rsp(200, ok, res, op, err);
      check($sformatf("bp%0d_rsp_seen", i), 32'(ok), 32'd1);
      check($sformatf("bp%0d_result", i), 32'(res), 32'(2 * i));
      check($sformatf("bp%0d_op", i), 32'(op), 32'd1);
    end
    flag = 1'b0;
    repeat (20) begin
      if (rsp_valid) flag = 1'b1;
      @(negedge clk);
    end
    check("bp_no_extra_rsp", 32'(flag), 32'd0);

    // Timeout: done never comes, queued command still runs afterwards
    model_hang = 1'b1;
    push_cmd(8'h12, 8'h34, 3'd1, 50, ok);
    check("to_push1", 32'(ok), 32'd1);
    push_cmd(8'h0F, 8'hF0, 3'd3, 50, ok);
    check("to_push2", 32'(ok), 32'd1);
    for (int i = 0; i < 20 && !alu_start; i++) @(negedge clk);
    hi = 0;
    while (alu_start && hi < 200) begin
      hi++;
      @(negedge clk);
    end
    check("to_start_cycles", 32'(hi), 32'(TIMEOUT));
    model_hang = 1'b0;
    get_rsp(10, ok, res, op, err);
    check("to_rsp_seen", 32'(ok), 32'd1);
    check("to_rsp", 32'({res, op, err}), 32'({16'h0000, 3'd1, 1'b1}));
    get_rsp(100, ok, res, op, err);
    check("to_next_rsp_seen", 32'(ok), 32'd1);
    check("to_next_rsp", 32'({res, op, err}), 32'({16'h00FF, 3'd3, 1'b0}));

    // Asynchronous reset while BUSY with commands queued
    model_hang = 1'b1;
    push_cmd(8'h11, 8'h22, 3'd4, 50, ok);
    push_cmd(8'h01, 8'h02, 3'd1, 50, ok);
    push_cmd(8'h03, 8'h04, 3'd1, 50, ok);
    for (int i = 0; i < 20 && !alu_start; i++) @(negedge clk);
    check("rst_busy_start_high", 32'(alu_start), 32'd1);
    repeat (3) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("rst_async_start", 32'(alu_start), 32'd0);
    check("rst_async_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_async_cmd_ready", 32'(cmd_ready), 32'd1);
    @(negedge clk);
    @(negedge clk);
    reset_n    = 1'b1;
    model_hang = 1'b0;
    flag = 1'b0;
    repeat (15) begin
      if (alu_start || rsp_valid) flag = 1'b1;
      @(negedge clk);
    end
    check("rst_fifo_empty", 32'(flag), 32'd0);
    push_cmd(8'h0F, 8'h3C, 3'd2, 50, ok);
    get_rsp(100, ok, res, op, err);
    check("rst_after_rsp_seen", 32'(ok), 32'd1);
    check("rst_after_rsp", 32'({res, op, err}), 32'({16'h000C, 3'd2, 1'b0}));

    check("min_start_gap_ge2", 32'(min_gap >= 2), 32'd1);
    check("pins_stable_while_start", 32'(stab_viol), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
